// File: rtl/io_bus_bridge.sv
// io_bus_bridge: splits the cpu byte bus into 128KB RAM and an I/O page at 0x3xxxx holding the
// UART TX/RX FIFOs and a free-running cycle counter; freezes the cpu while TX cannot accept.
module io_bus_bridge #(
    parameter int unsigned TX_DEPTH_LOG2 = 4,
    parameter int unsigned RX_DEPTH_LOG2 = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,
    output logic [16:0] ram_a,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        prog_done,
    output logic        rx_overflow
);
    localparam int unsigned TxDepth = 2 ** TX_DEPTH_LOG2;
    localparam int unsigned RxDepth = 2 ** RX_DEPTH_LOG2;

    typedef enum logic [2:0] {
        SelZero, SelRam, SelRx, SelCnt0, SelCnt1, SelCnt2, SelCnt3
    } sel_e;

    // Only addr[17:0] is decoded.
    logic unused_a;
    assign unused_a = ^cpu_a[31:18];

    logic is_io, is_data, is_ctrl, is_cnt;
    assign is_io   = (cpu_a[17:16] == 2'b11);
    assign is_data = is_io && (cpu_a[15:0] == 16'h0000);
    assign is_ctrl = is_io && (cpu_a[15:0] == 16'h0004);
    assign is_cnt  = is_io && (cpu_a[15:2] == 14'h0001);

    logic [TX_DEPTH_LOG2:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [RX_DEPTH_LOG2:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [7:0]             tx_mem_q [TxDepth];
    logic [7:0]             rx_mem_q [RxDepth];
    logic [7:0]             rx_byte_q, rx_byte_d;
    logic [31:0]            cycle_cnt_q, cycle_cnt_d;
    logic [31:0]            snapshot_q, snapshot_d;
    sel_e                   sel_q, sel_d;
    logic                   prog_done_q, prog_done_d;
    logic                   rx_overflow_q, rx_overflow_d;

    logic tx_empty, tx_full, rx_empty, rx_full;
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[TX_DEPTH_LOG2] != tx_rd_q[TX_DEPTH_LOG2]) &&
                      (tx_wr_q[TX_DEPTH_LOG2-1:0] == tx_rd_q[TX_DEPTH_LOG2-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[RX_DEPTH_LOG2] != rx_rd_q[RX_DEPTH_LOG2]) &&
                      (rx_wr_q[RX_DEPTH_LOG2-1:0] == rx_rd_q[RX_DEPTH_LOG2-1:0]);

    // A zero byte to the data port is dropped, so it never needs to stall.
    logic tx_req;
    assign tx_req  = cpu_wr && ((is_data && (cpu_dout != 8'h00)) || is_ctrl);
    assign cpu_rdy = rdy_in && !(tx_req && tx_full);

    logic rd_take, wr_take, tx_push, tx_pop, rx_pop_req, rx_pop, rx_push;
    logic [7:0] tx_wdata;
    assign rd_take    = cpu_rdy && !cpu_wr;
    assign wr_take    = cpu_rdy && cpu_wr;
    assign tx_push    = cpu_rdy && tx_req;
    assign tx_wdata   = is_ctrl ? 8'h00 : cpu_dout;
    assign tx_pop     = !tx_empty && tx_ready;
    assign rx_pop_req = rd_take && is_data;
    assign rx_pop     = rx_pop_req && !rx_empty;
    assign rx_push    = rx_valid && (!rx_full || rx_pop);

    assign ram_a     = cpu_a[16:0];
    assign ram_wdata = cpu_dout;
    assign ram_we    = wr_take && !is_io;

    assign tx_valid    = !tx_empty;
    assign tx_data     = tx_mem_q[tx_rd_q[TX_DEPTH_LOG2-1:0]];
    assign prog_done   = prog_done_q;
    assign rx_overflow = rx_overflow_q;

    always_comb begin
        tx_wr_d       = tx_wr_q;
        tx_rd_d       = tx_rd_q;
        rx_wr_d       = rx_wr_q;
        rx_rd_d       = rx_rd_q;
        rx_byte_d     = rx_byte_q;
        cycle_cnt_d   = cycle_cnt_q + 32'd1;
        snapshot_d    = snapshot_q;
        sel_d         = sel_q;
        prog_done_d   = prog_done_q;
        rx_overflow_d = rx_overflow_q;

        if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
        if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
        if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
        if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;

        if (rx_pop_req) begin
            rx_byte_d = rx_pop ? rx_mem_q[rx_rd_q[RX_DEPTH_LOG2-1:0]] : 8'h00;
        end
        if (rx_valid && rx_full && !rx_pop) rx_overflow_d = 1'b1;
        if (wr_take && is_ctrl)             prog_done_d   = 1'b1;
        if (rd_take && is_ctrl)             snapshot_d    = cycle_cnt_q;

        if (rd_take) begin
            if (!is_io) begin
                sel_d = SelRam;
            end else if (is_data) begin
                sel_d = SelRx;
            end else if (is_cnt) begin
                unique case (cpu_a[1:0])
                    2'd0:    sel_d = SelCnt0;
                    2'd1:    sel_d = SelCnt1;
                    2'd2:    sel_d = SelCnt2;
                    default: sel_d = SelCnt3;
                endcase
            end else begin
                sel_d = SelZero;
            end
        end
    end

    // Byte 0 of a 0x30004 read sees the snapshot taken on that same read.
    always_comb begin
        cpu_din = 8'h00;
        unique case (sel_q)
            SelRam:  cpu_din = ram_rdata;
            SelRx:   cpu_din = rx_byte_q;
            SelCnt0: cpu_din = snapshot_q[7:0];
            SelCnt1: cpu_din = snapshot_q[15:8];
            SelCnt2: cpu_din = snapshot_q[23:16];
            SelCnt3: cpu_din = snapshot_q[31:24];
            default: cpu_din = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            tx_wr_q       <= '0;
            tx_rd_q       <= '0;
            rx_wr_q       <= '0;
            rx_rd_q       <= '0;
            rx_byte_q     <= 8'h00;
            cycle_cnt_q   <= 32'd0;
            snapshot_q    <= 32'd0;
            sel_q         <= SelZero;
            prog_done_q   <= 1'b0;
            rx_overflow_q <= 1'b0;
        end else begin
            tx_wr_q       <= tx_wr_d;
            tx_rd_q       <= tx_rd_d;
            rx_wr_q       <= rx_wr_d;
            rx_rd_q       <= rx_rd_d;
            rx_byte_q     <= rx_byte_d;
            cycle_cnt_q   <= cycle_cnt_d;
            snapshot_q    <= snapshot_d;
            sel_q         <= sel_d;
            prog_done_q   <= prog_done_d;
            rx_overflow_q <= rx_overflow_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem_q[tx_wr_q[TX_DEPTH_LOG2-1:0]] <= tx_wdata;
        if (rx_push) rx_mem_q[rx_wr_q[RX_DEPTH_LOG2-1:0]] <= rx_data;
    end

endmodule
